// File: rtl/keyboard_movement_decoder_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// keyboard_movement_decoder_if
// Scancode byte stream from the PS/2 receiver into the movement decoder.
// Revision: 1.0
// ---------------------------------------------------------------------------
interface keyboard_movement_decoder_if;
  logic [7:0] scan_data;
  logic       scan_valid;

  modport master (output scan_data, output scan_valid);
  modport slave  (input  scan_data, input  scan_valid);
endinterface
`default_nettype wire

// File: rtl/keyboard_movement_decoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// keyboard_movement_decoder
// Turns PS/2 set-2 make/break scancodes into held movement levels.
// Revision: 1.0
// ---------------------------------------------------------------------------
module keyboard_movement_decoder #(
  parameter int ENABLE_WASD    = 1,
  parameter int PREFIX_TIMEOUT = 1000000
) (
  input  wire logic                  clock,
  input  wire logic                  reset,
  keyboard_movement_decoder_if.slave scan,
  output logic                       turn_right,
  output logic                       turn_left,
  output logic                       move_forward,
  output logic                       move_backward,
  output logic                       key_event,
  output logic                       prefix_error
);

  localparam int                 c_cnt_w        = $clog2(PREFIX_TIMEOUT) + 1;
  localparam logic [c_cnt_w-1:0] c_timeout_last = c_cnt_w'(PREFIX_TIMEOUT - 2);
  localparam logic [3:0]         c_wasd_gate    = (ENABLE_WASD != 0) ? 4'hF : 4'h0;
  localparam logic [7:0]         c_code_ext     = 8'hE0;
  localparam logic [7:0]         c_code_brk     = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_t;

  state_t               r_state;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [3:0]           r_arrow;
  logic [3:0]           r_wasd;
  logic [3:0]           r_out;
  logic                 r_key_event;
  logic                 r_prefix_error;

  state_t               w_state_nxt;
  logic [c_cnt_w-1:0]   w_cnt_nxt;
  logic [3:0]           w_arrow_nxt;
  logic [3:0]           w_wasd_nxt;
  logic [3:0]           w_out_nxt;
  logic [3:0]           w_arrow_mask;
  logic [3:0]           w_wasd_mask;
  logic                 w_timeout;

  // Bit order everywhere is {right, left, forward, backward}.
  always_comb begin
    w_arrow_mask = 4'b0000;
    w_wasd_mask  = 4'b0000;
    case (scan.scan_data)
      8'h74:   w_arrow_mask = 4'b1000;
      8'h6B:   w_arrow_mask = 4'b0100;
      8'h75:   w_arrow_mask = 4'b0010;
      8'h72:   w_arrow_mask = 4'b0001;
      8'h23:   w_wasd_mask  = 4'b1000;
      8'h1C:   w_wasd_mask  = 4'b0100;
      8'h1D:   w_wasd_mask  = 4'b0010;
      8'h1B:   w_wasd_mask  = 4'b0001;
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_arrow_nxt = r_arrow;
    w_wasd_nxt  = r_wasd;
    w_timeout   = 1'b0;
    if (scan.scan_valid) begin
      w_cnt_nxt   = '0;
      w_state_nxt = ST_IDLE;
      if (scan.scan_data == c_code_ext) begin
        w_state_nxt = ST_EXT;
      end else if (scan.scan_data == c_code_brk) begin
        w_state_nxt = (r_state == ST_EXT || r_state == ST_EXT_BRK) ? ST_EXT_BRK : ST_BRK;
      end else begin
        // Masks are zero for codes of the wrong family, so those bytes are no-ops.
        case (r_state)
          ST_IDLE:    w_wasd_nxt  = r_wasd  |  w_wasd_mask;
          ST_EXT:     w_arrow_nxt = r_arrow |  w_arrow_mask;
          ST_BRK:     w_wasd_nxt  = r_wasd  & ~w_wasd_mask;
          ST_EXT_BRK: w_arrow_nxt = r_arrow & ~w_arrow_mask;
          default:    ;
        endcase
      end
    end else if (r_state != ST_IDLE) begin
      // Abandon the prefix on the cycle the counter would reach PREFIX_TIMEOUT-1.
      if (r_cnt == c_timeout_last) begin
        w_timeout   = 1'b1;
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end else if (r_cnt != '1) begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
    end
    w_out_nxt = w_arrow_nxt | (w_wasd_nxt & c_wasd_gate);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_arrow        <= 4'b0000;
      r_wasd         <= 4'b0000;
      r_out          <= 4'b0000;
      r_key_event    <= 1'b0;
      r_prefix_error <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_arrow        <= w_arrow_nxt;
      r_wasd         <= w_wasd_nxt;
      r_out          <= w_out_nxt;
      r_key_event    <= (w_out_nxt != r_out);
      r_prefix_error <= w_timeout;
    end
  end

  assign turn_right    = r_out[3];
  assign turn_left     = r_out[2];
  assign move_forward  = r_out[1];
  assign move_backward = r_out[0];
  assign key_event     = r_key_event;
  assign prefix_error  = r_prefix_error;

endmodule
`default_nettype wire

// File: tb/tb_keyboard_movement_decoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_keyboard_movement_decoder
// Scoreboard bench: two decoders (WASD on/off) share one scancode stream.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_keyboard_movement_decoder;

  localparam int TMO = 16;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  keyboard_movement_decoder_if bus ();

  logic [3:0] out_a, out_b;
  logic       ke_a, ke_b, pe_a, pe_b;

  keyboard_movement_decoder #(.ENABLE_WASD(1), .PREFIX_TIMEOUT(TMO)) dut_a (
    .clock(clock), .reset(reset), .scan(bus.slave),
    .turn_right(out_a[3]), .turn_left(out_a[2]),
    .move_forward(out_a[1]), .move_backward(out_a[0]),
    .key_event(ke_a), .prefix_error(pe_a)
  );

  keyboard_movement_decoder #(.ENABLE_WASD(0), .PREFIX_TIMEOUT(TMO)) dut_b (
    .clock(clock), .reset(reset), .scan(bus.slave),
    .turn_right(out_b[3]), .turn_left(out_b[2]),
    .move_forward(out_b[1]), .move_backward(out_b[0]),
    .key_event(ke_b), .prefix_error(pe_b)
  );

  typedef struct packed {
    logic [3:0] out_a;
    logic       ke_a;
    logic       pe_a;
    logic [3:0] out_b;
    logic       ke_b;
    logic       pe_b;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: pending-prefix flags plus key tables.
  bit         pend_ext, pend_brk;
  int         idle;
  bit [3:0]   held_arrow, held_wasd, prev_a, prev_b;

  function automatic int arrow_idx(input logic [7:0] b);
    case (b)
      8'h74: return 3;
      8'h6B: return 2;
      8'h75: return 1;
      8'h72: return 0;
      default: return -1;
    endcase
  endfunction

  function automatic int wasd_idx(input logic [7:0] b);
    case (b)
      8'h23: return 3;
      8'h1C: return 2;
      8'h1D: return 1;
      8'h1B: return 0;
      default: return -1;
    endcase
  endfunction

  task automatic step(input bit rst_n, input bit v, input logic [7:0] d);
    exp_t     e;
    bit       perr;
    bit [3:0] na, nb;
    int       ai, wi;
    @(negedge clock);
    reset          = rst_n;
    bus.scan_valid = v;
    bus.scan_data  = d;
    if (!rst_n) begin
      pend_ext = 0; pend_brk = 0; idle = 0;
      held_arrow = '0; held_wasd = '0; prev_a = '0; prev_b = '0;
      e = '0;
    end else begin
      perr = 0;
      if (v) begin
        idle = 0;
        if (d == 8'hE0) begin
          pend_ext = 1; pend_brk = 0;
        end else if (d == 8'hF0) begin
          pend_brk = 1;
        end else begin
          ai = arrow_idx(d);
          wi = wasd_idx(d);
          if (pend_ext && ai >= 0)  held_arrow[ai] = !pend_brk;
          if (!pend_ext && wi >= 0) held_wasd[wi]  = !pend_brk;
          pend_ext = 0; pend_brk = 0;
        end
      end else if (pend_ext || pend_brk) begin
        idle++;
        if (idle == TMO - 1) begin
          pend_ext = 0; pend_brk = 0; idle = 0; perr = 1;
        end
      end
      na = held_arrow | held_wasd;
      nb = held_arrow;
      e.out_a = na; e.ke_a = (na != prev_a); e.pe_a = perr;
      e.out_b = nb; e.ke_b = (nb != prev_b); e.pe_b = perr;
      prev_a = na; prev_b = nb;
    end
    q.push_back(e);
  endtask

  task automatic send(input logic [7:0] b);
    step(1, 1, b);
  endtask

  task automatic wait_idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 8'h00);
  endtask

  // Monitor: one expected record per clock edge driven by the stimulus.
  exp_t m;
  always @(posedge clock) begin
    #1;
    if (q.size() > 0) begin
      m = q.pop_front();
      checks++;
      if ({out_a, ke_a, pe_a} !== {m.out_a, m.ke_a, m.pe_a}) begin
        failures++;
        $display("FAIL dut_wasd t=%0t got out=%b ke=%b pe=%b want out=%b ke=%b pe=%b",
                 $time, out_a, ke_a, pe_a, m.out_a, m.ke_a, m.pe_a);
      end
      checks++;
      if ({out_b, ke_b, pe_b} !== {m.out_b, m.ke_b, m.pe_b}) begin
        failures++;
        $display("FAIL dut_arrows t=%0t got out=%b ke=%b pe=%b want out=%b ke=%b pe=%b",
                 $time, out_b, ke_b, pe_b, m.out_b, m.ke_b, m.pe_b);
      end
    end
  end

  logic [7:0] pool [14];

  initial begin
    pool = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h1D,
             8'h1C, 8'h1B, 8'h23, 8'hE1, 8'h14, 8'h77, 8'hE0};
    reset          = 1'b0;
    bus.scan_valid = 1'b0;
    bus.scan_data  = 8'h00;

    step(0, 0, 8'h00);
    step(0, 1, 8'h1D);
    wait_idle(2);

    // Up make / break
    send(8'hE0); send(8'h75); wait_idle(2);
    send(8'hE0); send(8'hF0); send(8'h75); wait_idle(2);

    // Typematic W then release
    send(8'h1D); wait_idle(1); send(8'h1D); send(8'h1D); wait_idle(2);
    send(8'hF0); send(8'h1D); wait_idle(2);

    // Right arrow and D overlap
    send(8'hE0); send(8'h74); send(8'h23); wait_idle(1);
    send(8'hE0); send(8'hF0); send(8'h74); wait_idle(1);
    send(8'hF0); send(8'h23); wait_idle(2);

    // Prefix timeout, then unprefixed 75
    send(8'hE0); wait_idle(20);
    send(8'h75); wait_idle(2);
    send(8'hF0); wait_idle(20);
    send(8'hE0); send(8'hF0); wait_idle(TMO - 2); send(8'h75); wait_idle(3);

    // Reset in the middle of a release sequence
    send(8'hE0); send(8'h6B); wait_idle(1);
    send(8'hE0); send(8'hF0);
    step(0, 1, 8'h6B);
    send(8'h6B); wait_idle(2);

    // A alone, then Pause sequence with Up held
    send(8'h1C); wait_idle(1); send(8'hF0); send(8'h1C);
    send(8'hE0); send(8'h75); wait_idle(1);
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77); wait_idle(2);

    // Random traffic with gaps long enough to hit the timeout
    for (int n = 0; n < 1500; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2)
        step(0, $urandom_range(0, 1), pool[$urandom_range(0, 13)]);
      else if (r < 30)
        wait_idle($urandom_range(1, 18));
      else if (r < 36)
        send(8'($urandom));
      else
        send(pool[$urandom_range(0, 13)]);
    end
    wait_idle(2);

    @(posedge clock);
    #3;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d pending want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
